key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//  Debounces KEY_NUM active-low mechanical keys in parallel. Emits one-cycle press/release pulses and a
//  debounced level per key, and toggles one LED per key on each debounced press. Sits between the board
//  key pins and user logic; it replaces the single-key debounce/toggle block.
// PARAMETERS
//  KEY_NUM            4         number of independent key channels (1..16)
//  DEBOUNCE_CYCLES    500_000   cycles the input must stay stable before a state change (10 ms @ 50 MHz)
//  LONG_PRESS_CYCLES  50_000_000  cycles held after the debounced press before long_pulse fires (1 s @ 50 MHz)
// PORTS
//  sclk           in   1        system clock
//  s_rst_n        in   1        asynchronous, active-low reset
//  key            in   KEY_NUM  raw key pins, asynchronous, 0 = pressed
//  key_level      out  KEY_NUM  debounced state, 1 = pressed
//  press_pulse    out  KEY_NUM  one-cycle pulse on each debounced press
//  release_pulse  out  KEY_NUM  one-cycle pulse on each debounced release
//  long_pulse     out  KEY_NUM  one-cycle pulse on a long press (tied 0 unless LONG_PRESS_EN)
//  led            out  KEY_NUM  per-key LED; toggles on each press_pulse
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops = 1 (released); counters = 0; all channels in RELEASED.
//  - Per channel: 2-flop synchroniser on key[i]. The debounce logic uses only the second flop (ks).
//  - Per-channel FSM, 2 states:
//    RELEASED: if ks==0, cnt++; else cnt<=0. If ks==0 && cnt==DEBOUNCE_CYCLES-1: go to PRESSED,
//      cnt<=0, press_pulse<=1, key_level<=1, led<=~led.
//    PRESSED: if ks==1, cnt++; else cnt<=0. If ks==1 && cnt==DEBOUNCE_CYCLES-1: go to RELEASED,
//      cnt<=0, release_pulse<=1, key_level<=0.
//  - Any bounce back to the stable level clears cnt. A glitch shorter than DEBOUNCE_CYCLES produces no event.
//  - Latency: a clean edge on key[i] gives a pulse DEBOUNCE_CYCLES+2 cycles later (+1 for async sampling).
//  - All pulse outputs are registered and high for exactly one cycle. led and key_level are registered.
//  - Counter width: $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1). The counter never wraps because it
//    is cleared or saturates at its terminal value.
//  - Channels are fully independent. Simultaneous events on several keys each produce their own pulse
//    in the same cycle.
//  - Key held low through reset release: the press is detected DEBOUNCE_CYCLES+2 cycles after reset
//    deasserts. Reset mid-debounce discards the partial count.
// CONFIGURATION
//  Macro KEY_LONG_PRESS_EN:
//  - Defined: each channel has a hold counter, cleared on entry to PRESSED. It increments while PRESSED
//    and saturates. When it equals LONG_PRESS_CYCLES-1, long_pulse[i]<=1 for one cycle, once per press.
//    A release before that point gives no long_pulse. The LED still toggles only on press.
//  - Undefined: no hold counter is built; long_pulse = '0.
// STRUCTURE
//  - Shared package key_pkg: FSM state encodings (ST_RELEASED=1'b0, ST_PRESSED=1'b1) and default timing
//    constants for a 50 MHz clock.
//  - Sub-module key_debounce_ch: one channel, containing the synchroniser, FSM, counters and LED flop.
//    The top instantiates it KEY_NUM times with a generate loop.
// TESTING (sim: DEBOUNCE_CYCLES=20, LONG_PRESS_CYCLES=100, KEY_NUM=4)
//  1. Reset with all keys=1 -> all outputs 0. Hold key[0]=0 -> press_pulse[0] one cycle at 22..23 cycles,
//     key_level[0]=1, led[0]=1.
//  2. key[1] bounces 0/1 every 5 cycles for 60 cycles, then is stable 0 -> exactly one press_pulse[1],
//     20..23 cycles after it becomes stable.
//  3. Press then release key[2]; a second press/release -> release_pulse[2] after each release.
//     led[2] goes 1 then 0.
//  4. key[0]..key[3] all go 0 in the same cycle -> all four press_pulse bits rise in the same cycle.
//  5. KEY_LONG_PRESS_EN, key[3] held 200 cycles -> one long_pulse[3] 100 cycles after press_pulse[3];
//     held 50 cycles -> none. Without the macro, long_pulse stays 0.
//  6. Assert s_rst_n=0 10 cycles into a debounce on key[0] -> no pulse, led=0. After release with key
//     held low, press_pulse appears 22..23 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer: channel state encoding,
// 50 MHz default timing and the counter width helper.
package key_pkg;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 500_000;     // 10 ms @ 50 MHz
  localparam int DEF_LONG_PRESS_CYCLES = 50_000_000;  // 1 s @ 50 MHz

  // Wide enough to hold the larger terminal value without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, two-state debounce FSM, LED toggle.
// Long-press hold counter is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic led_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d, ks_q, ks_d;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d, rel_q, rel_d;
  logic          level_q, level_d, led_q, led_d;

  // Next-state logic: count cycles at the opposite level; any bounce clears the count.
  always_comb begin
    sync1_d = key_i;
    ks_d    = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    level_d = level_q;
    led_d   = led_q;
    case (state_q)
      ST_RELEASED: begin
        if (!ks_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = {CW{1'b0}};
            press_d = 1'b1;
            level_d = 1'b1;
            led_d   = ~led_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      ST_PRESSED: begin
        if (ks_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = {CW{1'b0}};
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Channel state registers; synchroniser resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      ks_q    <= 1'b1;
      state_q <= ST_RELEASED;
      cnt_q   <= {CW{1'b0}};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      ks_q    <= ks_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] LP_SAT  = CW'(LONG_PRESS_CYCLES);

  logic [CW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold counter saturates one past the trigger value so the pulse fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = {CW{1'b0}};
    end else if (state_q == ST_PRESSED) begin
      if (hold_q == LP_LAST) begin
        long_d = 1'b1;
      end else begin
        long_d = 1'b0;
      end
      if (hold_q != LP_SAT) begin
        hold_d = hold_q + CW'(1);
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // Long-press registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= {CW{1'b0}};
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign led_o     = led_q;

endmodule

// File: rtl/key_debounce_multi.sv
// KEY_NUM independent active-low key debouncers with press/release pulses and LED toggle.
// Define KEY_LONG_PRESS_EN to enable per-key long-press pulses.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int KEY_NUM           = 4,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] press_pulse,
  output logic [KEY_NUM-1:0] release_pulse,
  output logic [KEY_NUM-1:0] long_pulse,
  output logic [KEY_NUM-1:0] led
);

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk      (sclk),
      .rst_n    (s_rst_n),
      .key_i    (key[gi]),
      .level_o  (key_level[gi]),
      .press_o  (press_pulse[gi]),
      .release_o(release_pulse[gi]),
      .long_o   (long_pulse[gi]),
      .led_o    (led[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: expected pulse events are queued as keys
// are driven and matched against observed pulses by a monitor.
module tb_key_debounce_multi;

  localparam int KN = 4;
  localparam int DB = 20;
  localparam int LP = 100;

  logic          clk;
  logic          rst_n;
  logic [KN-1:0] key;
  logic [KN-1:0] key_level, press_pulse, release_pulse, long_pulse, led;

  key_debounce_multi #(
    .KEY_NUM(KN), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .sclk(clk), .s_rst_n(rst_n), .key(key), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .led(led)
  );

  typedef struct {
    int            kind;  // 0 press, 1 release, 2 long
    logic [KN-1:0] mask;
    int            lo;
    int            hi;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [KN-1:0] mask, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.mask = mask; e.lo = lo; e.hi = hi;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  exp_t          mon_e;
  logic [KN-1:0] mon_vec;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       mon_vec = press_pulse;
        1:       mon_vec = release_pulse;
        default: mon_vec = long_pulse;
      endcase
      if (mon_vec != '0) begin
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_pulse_kind%0d", k), 32'(mon_vec), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("event_kind", 32'(k), 32'(mon_e.kind));
          chk("event_mask", 32'(mon_vec), 32'(mon_e.mask));
          chk("latency_min", 32'(cyc >= mon_e.lo), 32'd1);
          chk("latency_max", 32'(cyc <= mon_e.hi), 32'd1);
        end
      end
    end
  end

  initial begin
    int t;
    key   = 4'hF;
    rst_n = 1'b0;
    step(3);
    chk("rst_level",   32'(key_level),     32'd0);
    chk("rst_press",   32'(press_pulse),   32'd0);
    chk("rst_release", 32'(release_pulse), 32'd0);
    chk("rst_long",    32'(long_pulse),    32'd0);
    chk("rst_led",     32'(led),           32'd0);
    rst_n = 1'b1;
    step(2);

    // 1: clean press and release on key 0
    key[0] = 1'b0; t = cyc; push(0, 4'b0001, t + DB + 2, t + DB + 3);
    step(30);
    chk("t1_level", 32'(key_level), 32'h1);
    chk("t1_led",   32'(led),       32'h1);
    key[0] = 1'b1; t = cyc; push(1, 4'b0001, t + DB + 2, t + DB + 3);
    step(30);
    chk("t1_level_rel", 32'(key_level), 32'h0);

    // 2: bouncing key 1, then stable low
    for (int i = 0; i < 12; i++) begin
      key[1] = i[0];
      step(5);
    end
    key[1] = 1'b0; t = cyc; push(0, 4'b0010, t + DB, t + DB + 3);
    step(30);
    chk("t2_level", 32'(key_level), 32'h2);
    chk("t2_led",   32'(led),       32'h3);
    key[1] = 1'b1; t = cyc; push(1, 4'b0010, t + DB + 2, t + DB + 3);
    step(30);

    // 3: two press/release cycles on key 2
    for (int r = 0; r < 2; r++) begin
      key[2] = 1'b0; t = cyc; push(0, 4'b0100, t + DB + 2, t + DB + 3);
      step(30);
      chk("t3_led2", 32'(led[2]), (r == 0) ? 32'd1 : 32'd0);
      key[2] = 1'b1; t = cyc; push(1, 4'b0100, t + DB + 2, t + DB + 3);
      step(30);
    end
    chk("t3_level", 32'(key_level), 32'h0);

    // 4: all keys together
    key = 4'h0; t = cyc; push(0, 4'b1111, t + DB + 2, t + DB + 3);
    step(30);
    chk("t4_level", 32'(key_level), 32'hF);
    chk("t4_led",   32'(led),       32'hC);
    key = 4'hF; t = cyc; push(1, 4'b1111, t + DB + 2, t + DB + 3);
    step(30);

    // 5: long hold then short hold on key 3
    key[3] = 1'b0; t = cyc; push(0, 4'b1000, t + DB + 2, t + DB + 3);
`ifdef KEY_LONG_PRESS_EN
    push(2, 4'b1000, t + DB + 2 + LP, t + DB + 3 + LP);
`endif
    step(200);
    key[3] = 1'b1; t = cyc; push(1, 4'b1000, t + DB + 2, t + DB + 3);
    step(30);
    key[3] = 1'b0; t = cyc; push(0, 4'b1000, t + DB + 2, t + DB + 3);
    step(50);
    key[3] = 1'b1; t = cyc; push(1, 4'b1000, t + DB + 2, t + DB + 3);
    step(150);
    chk("t5_level", 32'(key_level), 32'h0);

    // 6: reset in the middle of a debounce, key kept low
    key[0] = 1'b0;
    step(10);
    rst_n = 1'b0;
    step(3);
    chk("t6_rst_level", 32'(key_level), 32'h0);
    chk("t6_rst_led",   32'(led),       32'h0);
    rst_n = 1'b1; t = cyc; push(0, 4'b0001, t + DB + 2, t + DB + 3);
    step(30);
    chk("t6_level", 32'(key_level), 32'h1);
    chk("t6_led",   32'(led),       32'h1);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
